// File: rtl/mmio_ctrl_regs.sv
// mmio_ctrl_regs_pkg: bus, OBI and main-FSM types shared with the controller.
// mmio_ctrl_regs: MMIO control/status register file for the CGRA.
//   clk_i, rst_ni         clock, synchronous active-low reset
//   reg_req_i/reg_rsp_o   zero-wait register bus (ready = valid)
//   start_o               one-cycle start pulse after an accepted start
//   conf_change_o         one-cycle pulse after clr_conf
//   irq_o                 irq_en & exec_done
//   exec_done_i           execution-complete pulse (clears busy)
//   conf_done_i           configuration-complete pulse
//   state_i               main FSM state (selects the CONF/EXEC counters)
//   masters_req_i/resp_i  OBI masters watched for stalls (req & !gnt)
//   conf_addr_o, imn_*_o, omn_*_o   parameter registers driven to the datapath
package mmio_ctrl_regs_pkg;
    typedef struct packed {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } reg_req_t;

    typedef struct packed {
        logic        ready;
        logic [31:0] rdata;
        logic        error;
    } reg_rsp_t;

    typedef enum logic [1:0] {
        S_MAIN_IDLE = 2'd0,
        S_MAIN_WAIT = 2'd1,
        S_MAIN_EXEC = 2'd2,
        S_MAIN_DONE = 2'd3
    } main_fsm_t;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;
endpackage

module mmio_ctrl_regs
    import mmio_ctrl_regs_pkg::*;
#(
    parameter int unsigned IN_NODES    = 4,
    parameter int unsigned OUT_NODES   = 4,
    parameter int unsigned NUM_MASTERS = IN_NODES + OUT_NODES,
    parameter int unsigned CTR_W       = 32
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  reg_req_t                           reg_req_i,
    output reg_rsp_t                           reg_rsp_o,
    output logic                               start_o,
    output logic                               conf_change_o,
    output logic                               irq_o,
    input  logic                               exec_done_i,
    input  logic                               conf_done_i,
    input  main_fsm_t                          state_i,
    input  obi_req_t  [NUM_MASTERS-1:0]        masters_req_i,
    input  obi_resp_t [NUM_MASTERS-1:0]        masters_resp_i,
    output logic [31:0]                        conf_addr_o,
    output logic [IN_NODES-1:0][31:0]          imn_addr_o,
    output logic [IN_NODES-1:0][15:0]          imn_size_o,
    output logic [IN_NODES-1:0][15:0]          imn_stride_o,
    output logic [OUT_NODES-1:0][31:0]         omn_addr_o,
    output logic [OUT_NODES-1:0][15:0]         omn_size_o
);

    localparam int unsigned CTR_TOTAL = 0;
    localparam int unsigned CTR_CONF  = 1;
    localparam int unsigned CTR_EXEC  = 2;
    localparam int unsigned CTR_STALL = 3;

    // Byte-lane merge of a bus write into an existing 32-bit register image.
    function automatic logic [31:0] merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  strb);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{strb[b]}};
        return (old_v & ~m) | (new_v & m);
    endfunction

    // ---------------- state ----------------
    logic [31:0]                 conf_addr_q, conf_addr_d;
    logic [IN_NODES-1:0][31:0]   imn_addr_q, imn_addr_d;
    logic [IN_NODES-1:0][15:0]   imn_size_q, imn_size_d;
    logic [IN_NODES-1:0][15:0]   imn_stride_q, imn_stride_d;
    logic [OUT_NODES-1:0][31:0]  omn_addr_q, omn_addr_d;
    logic [OUT_NODES-1:0][15:0]  omn_size_q, omn_size_d;
    logic                        perf_en_q, perf_en_d;
    logic                        irq_en_q, irq_en_d;
    logic                        busy_q, busy_d;
    logic                        exec_done_q, exec_done_d;
    logic                        conf_done_q, conf_done_d;
    logic                        ctr_ovf_q, ctr_ovf_d;
    logic                        start_q, start_d;
    logic                        conf_change_q, conf_change_d;
    logic [3:0][CTR_W-1:0]       ctr_q, ctr_d;

    // ---------------- address decode ----------------
    logic [9:0] woff, node_off;
    logic [8:0] node_idx;
    logic       node_hi, aligned, in_node_space;
    logic       is_ctrl, is_status, is_conf, is_ctr, is_imn, is_omn, mapped;

    assign woff          = reg_req_i.addr[11:2];
    assign node_off      = woff - 10'd8;           // node registers start at 0x20
    assign node_idx      = node_off[9:1];          // two words per node
    assign node_hi       = node_off[0];            // 0: ADDR, 1: PARAM/SIZE
    assign aligned       = (reg_req_i.addr[1:0] == 2'b00);
    assign in_node_space = (woff >= 10'd8);
    assign is_ctrl       = (woff == 10'd0);
    assign is_status     = (woff == 10'd1);
    assign is_conf       = (woff == 10'd2);
    assign is_ctr        = (woff >= 10'd3) && (woff <= 10'd6);
    assign is_imn        = in_node_space && (node_idx < 9'(IN_NODES));
    assign is_omn        = in_node_space && !is_imn &&
                           (node_idx < 9'(IN_NODES + OUT_NODES));
    assign mapped        = aligned &&
                           (is_ctrl || is_status || is_conf || is_ctr || is_imn || is_omn);

    // ---------------- bus response and register writes ----------------
    logic start_acc, clr_param, clr_conf, perf_rst, w1c_done, w1c_ovf;
    logic [31:0] wd;

    assign wd = reg_req_i.wdata;

    always_comb begin
        reg_rsp_o       = '0;
        reg_rsp_o.ready = reg_req_i.valid;
        conf_addr_d     = conf_addr_q;
        imn_addr_d      = imn_addr_q;
        imn_size_d      = imn_size_q;
        imn_stride_d    = imn_stride_q;
        omn_addr_d      = omn_addr_q;
        omn_size_d      = omn_size_q;
        perf_en_d       = perf_en_q;
        irq_en_d        = irq_en_q;
        start_acc       = 1'b0;
        clr_param       = 1'b0;
        clr_conf        = 1'b0;
        perf_rst        = 1'b0;
        w1c_done        = 1'b0;
        w1c_ovf         = 1'b0;

        if (reg_req_i.valid) begin
            if (!mapped) begin
                reg_rsp_o.error = 1'b1;
            end else if (!reg_req_i.write) begin
                if (is_ctrl)
                    reg_rsp_o.rdata = {26'd0, irq_en_q, 1'b0, perf_en_q, 3'd0};
                if (is_status)
                    reg_rsp_o.rdata = {28'd0, ctr_ovf_q, busy_q, conf_done_q, exec_done_q};
                if (is_conf)
                    reg_rsp_o.rdata = conf_addr_q;
                if (woff == 10'd3) reg_rsp_o.rdata = 32'(ctr_q[CTR_TOTAL]);
                if (woff == 10'd4) reg_rsp_o.rdata = 32'(ctr_q[CTR_CONF]);
                if (woff == 10'd5) reg_rsp_o.rdata = 32'(ctr_q[CTR_EXEC]);
                if (woff == 10'd6) reg_rsp_o.rdata = 32'(ctr_q[CTR_STALL]);
                for (int i = 0; i < IN_NODES; i++) begin
                    if (is_imn && node_idx == 9'(i))
                        reg_rsp_o.rdata = node_hi ? {imn_stride_q[i], imn_size_q[i]}
                                                  : imn_addr_q[i];
                end
                for (int j = 0; j < OUT_NODES; j++) begin
                    if (is_omn && node_idx == 9'(IN_NODES + j))
                        reg_rsp_o.rdata = node_hi ? {16'd0, omn_size_q[j]}
                                                  : omn_addr_q[j];
                end
            end else if (is_ctrl) begin
                if (reg_req_i.wstrb[0]) begin
                    // A rejected start/clr_param drops the whole CTRL write so
                    // software never sees a half-applied command.
                    if (busy_q && (wd[0] || wd[1])) begin
                        reg_rsp_o.error = 1'b1;
                    end else begin
                        start_acc = wd[0];
                        clr_param = wd[1];
                        clr_conf  = wd[2];
                        perf_en_d = wd[3];
                        perf_rst  = wd[4];
                        irq_en_d  = wd[5];
                    end
                end
            end else if (is_status) begin
                if (reg_req_i.wstrb[0]) begin
                    w1c_done = wd[0];
                    w1c_ovf  = wd[3];
                end
            end else if (is_ctr) begin
                // counters are read-only; writes are silently ignored
            end else if (busy_q) begin
                reg_rsp_o.error = 1'b1;    // parameters locked during execution
            end else if (is_conf) begin
                conf_addr_d = merge(conf_addr_q, wd, reg_req_i.wstrb);
            end else begin
                for (int i = 0; i < IN_NODES; i++) begin
                    if (is_imn && node_idx == 9'(i)) begin
                        if (node_hi)
                            {imn_stride_d[i], imn_size_d[i]} =
                                merge({imn_stride_q[i], imn_size_q[i]}, wd, reg_req_i.wstrb);
                        else
                            imn_addr_d[i] = merge(imn_addr_q[i], wd, reg_req_i.wstrb);
                    end
                end
                for (int j = 0; j < OUT_NODES; j++) begin
                    if (is_omn && node_idx == 9'(IN_NODES + j)) begin
                        if (node_hi)
                            omn_size_d[j] = merge({16'd0, omn_size_q[j]}, wd,
                                                  reg_req_i.wstrb) & 32'h0000_FFFF;
                        else
                            omn_addr_d[j] = merge(omn_addr_q[j], wd, reg_req_i.wstrb);
                    end
                end
            end
        end

        // clr_param overrides any parameter write computed above
        if (clr_param) begin
            conf_addr_d  = '0;
            imn_addr_d   = '0;
            imn_size_d   = '0;
            imn_stride_d = '0;
            omn_addr_d   = '0;
            omn_size_d   = '0;
        end
    end

    // ---------------- status flags, pulses, counters ----------------
    logic             stall;
    logic [3:0]       ctr_inc;
    logic             ovf_set;

    always_comb begin
        stall = 1'b0;
        for (int m = 0; m < NUM_MASTERS; m++)
            stall = stall | (masters_req_i[m].req & ~masters_resp_i[m].gnt);
    end

    always_comb begin
        busy_d = busy_q;
        if (start_acc)        busy_d = 1'b1;
        else if (exec_done_i) busy_d = 1'b0;

        // clear by command > set by hardware > W1C
        exec_done_d = exec_done_q;
        if (start_acc || clr_param) exec_done_d = 1'b0;
        else if (exec_done_i)       exec_done_d = 1'b1;
        else if (w1c_done)          exec_done_d = 1'b0;

        conf_done_d = conf_done_q;
        if (clr_conf)         conf_done_d = 1'b0;
        else if (conf_done_i) conf_done_d = 1'b1;

        start_d       = start_acc;
        conf_change_d = clr_conf;

        ctr_inc[CTR_TOTAL] = 1'b1;
        ctr_inc[CTR_CONF]  = (state_i == S_MAIN_WAIT);
        ctr_inc[CTR_EXEC]  = (state_i == S_MAIN_EXEC);
        ctr_inc[CTR_STALL] = stall;

        ctr_d   = ctr_q;
        ovf_set = 1'b0;
        if (perf_rst) begin
            ctr_d = '0;
        end else if (perf_en_q) begin
            for (int k = 0; k < 4; k++) begin
                if (ctr_inc[k]) begin
                    if (&ctr_q[k]) ovf_set  = 1'b1;   // saturate, flag overflow
                    else           ctr_d[k] = ctr_q[k] + 1'b1;
                end
            end
        end

        // perf_rst deliberately leaves the sticky flag alone
        ctr_ovf_d = ctr_ovf_q;
        if (ovf_set)      ctr_ovf_d = 1'b1;
        else if (w1c_ovf) ctr_ovf_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            conf_addr_q   <= '0;
            imn_addr_q    <= '0;
            imn_size_q    <= '0;
            imn_stride_q  <= '0;
            omn_addr_q    <= '0;
            omn_size_q    <= '0;
            perf_en_q     <= 1'b0;
            irq_en_q      <= 1'b0;
            busy_q        <= 1'b0;
            exec_done_q   <= 1'b0;
            conf_done_q   <= 1'b0;
            ctr_ovf_q     <= 1'b0;
            start_q       <= 1'b0;
            conf_change_q <= 1'b0;
            ctr_q         <= '0;
        end else begin
            conf_addr_q   <= conf_addr_d;
            imn_addr_q    <= imn_addr_d;
            imn_size_q    <= imn_size_d;
            imn_stride_q  <= imn_stride_d;
            omn_addr_q    <= omn_addr_d;
            omn_size_q    <= omn_size_d;
            perf_en_q     <= perf_en_d;
            irq_en_q      <= irq_en_d;
            busy_q        <= busy_d;
            exec_done_q   <= exec_done_d;
            conf_done_q   <= conf_done_d;
            ctr_ovf_q     <= ctr_ovf_d;
            start_q       <= start_d;
            conf_change_q <= conf_change_d;
            ctr_q         <= ctr_d;
        end
    end

    assign start_o       = start_q;
    assign conf_change_o = conf_change_q;
    assign irq_o         = irq_en_q & exec_done_q;
    assign conf_addr_o   = conf_addr_q;
    assign imn_addr_o    = imn_addr_q;
    assign imn_size_o    = imn_size_q;
    assign imn_stride_o  = imn_stride_q;
    assign omn_addr_o    = omn_addr_q;
    assign omn_size_o    = omn_size_q;

    // Only req/gnt of the OBI buses and addr[11:0] of the register bus matter.
    logic unused_bits;
    assign unused_bits = ^{reg_req_i.addr[31:12], masters_req_i, masters_resp_i};

endmodule

// File: doc/mmio_ctrl_regs.md
# mmio_ctrl_regs

Parametrised MMIO control/status register file for the CGRA, sitting between the `reg_req_t`/`reg_rsp_t` peripheral bus and the main controller. It generalises the control block to any number of input and output memory nodes and implements the register file directly in RTL, without a generated register top. It adds:
- a busy interlock that protects parameters during execution;
- saturating performance counters with a sticky overflow flag;
- an exec-done interrupt.

## Interface
- `IN_NODES`, default 4: number of input memory nodes (1..16).
- `OUT_NODES`, default 4: number of output memory nodes (1..16).
- `NUM_MASTERS`, default `IN_NODES+OUT_NODES`: OBI masters monitored for stalls.
- `CTR_W`, default 32: performance counter width (16..32); read data zero-extended.
- `clk_i`  in  1  single clock, all state on rising edge.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `reg_req_i`  in  `reg_req_t`  bus request (valid, write, addr, wdata, wstrb).
- `reg_rsp_o`  out  `reg_rsp_t`  bus response (ready, rdata, error).
- `start_o`  out  1  one-cycle execution start pulse.
- `conf_change_o`  out  1  one-cycle configuration-invalidate pulse.
- `irq_o`  out  1  level interrupt, `irq_en & exec_done`.
- `exec_done_i`  in  1  execution-complete pulse.
- `conf_done_i`  in  1  configuration-complete pulse.
- `state_i`  in  `main_fsm_t`  main FSM state.
- `masters_req_i`  in  `obi_req_t [NUM_MASTERS]`  OBI requests.
- `masters_resp_i`  in  `obi_resp_t [NUM_MASTERS]`  OBI responses.
- `conf_addr_o`  out  32  configuration base address.
- `imn_addr_o`  out  32 x `IN_NODES`  input node base addresses.
- `imn_size_o`  out  16 x `IN_NODES`  input node sizes.
- `imn_stride_o`  out  16 x `IN_NODES`  input node strides.
- `omn_addr_o`  out  32 x `OUT_NODES`  output node base addresses.
- `omn_size_o`  out  16 x `OUT_NODES`  output node sizes.

## Operation
Register map uses byte offsets on `addr[11:0]`, word-aligned.
- **0x00 CTRL**
  - bit0 start: write-1 pulse.
  - bit1 clr_param: write-1 pulse.
  - bit2 clr_conf: write-1 pulse.
  - bit3 perf_en: RW.
  - bit4 perf_rst: write-1 pulse.
  - bit5 irq_en: RW.
  - Pulse bits read 0.
- **0x04 STATUS**
  - bit0 exec_done: W1C.
  - bit1 conf_done: RO.
  - bit2 busy: RO.
  - bit3 ctr_ovf: W1C.
- **0x08** CONF_ADDR.
- **0x0C..0x18** counters TOTAL, CONF, EXEC, STALL: RO, writes ignored without error.
- **Input nodes:** 0x20+8i is IMN_i ADDR; 0x24+8i is IMN_i PARAM (size [15:0], stride [31:16]).
- **Output nodes:** base B = 0x20+8·IN_NODES. B+8j is OMN_j ADDR; B+4+8j is OMN_j SIZE [15:0].
- **Invalid access:** unmapped or unaligned address gives error=1, rdata=0, no state change.

Write semantics:
- `wstrb` gates bytes of RW registers.
- CTRL command bits act only if `wstrb[0]`.

busy:
- Set by an accepted start.
- Cleared by `exec_done_i`.
- While busy:
  - writes to CONF_ADDR/IMN/OMN and clr_param are dropped with error=1;
  - a start is dropped with error=1.

Status rules:
- exec_done: set by `exec_done_i`; cleared by clr_param, accepted start or W1C. Set beats W1C in the same cycle; clear by clr_param/start beats set.
- conf_done: set by `conf_done_i`; cleared by clr_conf. Clear wins.

Counters, when perf_en:
- TOTAL: every cycle.
- CONF: while `state_i==S_MAIN_WAIT`.
- EXEC: while `state_i==S_MAIN_EXEC`.
- STALL: any master with `req & !gnt`.

Counter saturation and reset:
- At all-ones a counter holds and sets ctr_ovf.
- perf_rst zeroes all four and has priority over increment. It does not clear ctr_ovf.

clr_param zeroes CONF_ADDR and all IMN/OMN fields. A same-cycle write to those registers loses.

## Timing
- Response is zero-wait: `ready=valid` combinationally; rdata/error combinational from current registers.
- Writes take effect at the next edge. Reads in that cycle return the old value.
- `start_o`/`conf_change_o` assert exactly one cycle, in the cycle after the accepting write edge.
- busy and exec_done update at the same edge as the write.
- `irq_o` asserts the cycle after exec_done sets with irq_en=1. It drops the cycle after the clear.
- Reset (`rst_ni` low at edge):
  - all registers, counters and flags go to 0;
  - all outputs go to 0;
  - any pulse in flight is cancelled.
  - Reset mid-execution clears busy.

## Test plan
- **Reset:** hold rst_ni low 2 cycles, then read every mapped register -> all 0, no error; read 0x400 -> error=1, rdata=0.
- **Parameters:**
  - write IMN_1 PARAM=0x0004_0100 -> size_o[1]=0x100, stride_o[1]=4;
  - write OMN_0 ADDR with wstrb=0b0011 data 0xAABB_CCDD -> 0x0000_CCDD;
  - write CTRL=0x2 -> all parameter outputs 0.
- **Busy interlock:**
  - write CTRL=0x1 -> start_o high 1 cycle, busy=1;
  - write IMN_0 ADDR=0x1234 -> error=1, value unchanged;
  - second start -> error, no pulse;
  - pulse exec_done_i -> busy=0, exec_done=1.
- **Interrupt and collision:**
  - with irq_en=1, pulse exec_done_i -> irq_o=1;
  - W1C STATUS bit0 in the same cycle as another exec_done_i pulse -> exec_done stays 1;
  - W1C next cycle -> irq_o=0.
- **Counters:**
  - perf_en=1, state_i=S_MAIN_EXEC for 10 cycles, master 2 req=1 gnt=0 for 3 cycles -> EXEC=10, STALL=3;
  - perf_rst -> all 0.
- **Saturation:** CTR_W=16, perf_en for 65540 cycles -> TOTAL=0xFFFF, ctr_ovf=1; W1C bit3 -> 0, TOTAL stays 0xFFFF.
